// File: rtl/log_seq_unit.sv
// Registered logic/compare unit with valid/ready handshake and multi-word chained compare (MSW first).
// Optional: define LOGS_ZERO_FLAG_EN to drive FLAG_out[ZERO_BIT] with (result==0) in logic modes.
module log_seq_unit #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FLAG_W   = 16,
  parameter int unsigned EQ_BIT   = 9,
  parameter int unsigned GT_BIT   = 8,
  parameter int unsigned LT_BIT   = 7,
  parameter int unsigned ZERO_BIT = 6
) (
  input  logic              LOGS_CLK,
  input  logic              LOGS_RST,
  input  logic              LOGS_IN_VALID,
  output logic              LOGS_IN_READY,
  input  logic [DATA_W-1:0] LOGS_IN1,
  input  logic [DATA_W-1:0] LOGS_IN0,
  input  logic [2:0]        LOGS_MODE,
  input  logic [2:0]        LOGS_CMODE,
  input  logic              LOGS_SIGNED,
  input  logic              LOGS_CHAIN,
  input  logic [FLAG_W-1:0] LOGS_FLAG_in,
  output logic              LOGS_OUT_VALID,
  input  logic              LOGS_OUT_READY,
  output logic [DATA_W-1:0] LOGS_OUT,
  output logic [FLAG_W-1:0] LOGS_FLAG_out
);

  localparam logic [2:0] MODE_CMP = 3'b111;

  typedef enum logic [0:0] {ST_IDLE, ST_CHAIN} state_t;
  typedef enum logic [1:0] {REL_EQ, REL_GT, REL_LT} rel_t;

  state_t            state_q, state_nxt;
  rel_t              rel_q, rel_nxt, word_rel, fin_rel;
  logic              decided_q, decided_nxt;
  logic              accept, is_cmp, is_final, load, use_signed;
  logic [DATA_W-1:0] logic_res, out_nxt;
  logic [FLAG_W-1:0] flag_nxt;

  assign LOGS_IN_READY = !LOGS_OUT_VALID || LOGS_OUT_READY;
  assign accept        = LOGS_IN_VALID && LOGS_IN_READY;
  assign is_cmp        = (LOGS_MODE == MODE_CMP);
  assign is_final      = !is_cmp || !LOGS_CHAIN;
  assign load          = accept && is_final;

  // State register
  always_ff @(posedge LOGS_CLK) begin
    if (LOGS_RST) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  // Next state: any non-final compare word keeps/enters CHAIN, anything else returns to IDLE
  always_comb begin
    state_nxt = state_q;
    if (accept) begin
      if (is_cmp && LOGS_CHAIN) state_nxt = ST_CHAIN;
      else                      state_nxt = ST_IDLE;
    end
  end

  // Datapath, chain accumulator update and result formation
  always_comb begin
    logic_res   = '0;
    word_rel    = REL_EQ;
    fin_rel     = REL_EQ;
    rel_nxt     = rel_q;
    decided_nxt = decided_q;
    out_nxt     = '0;
    flag_nxt    = LOGS_FLAG_in;

    case (LOGS_MODE)
      3'b000:  logic_res = ~LOGS_IN1;
      3'b001:  logic_res = LOGS_IN1 & LOGS_IN0;
      3'b010:  logic_res = ~(LOGS_IN1 & LOGS_IN0);
      3'b011:  logic_res = LOGS_IN1 | LOGS_IN0;
      3'b100:  logic_res = ~(LOGS_IN1 | LOGS_IN0);
      3'b101:  logic_res = LOGS_IN1 ^ LOGS_IN0;
      3'b110:  logic_res = ~(LOGS_IN1 ^ LOGS_IN0);
      default: logic_res = '0;
    endcase

    // Signedness only applies to the first (most significant) word
    use_signed = (state_q == ST_IDLE) && LOGS_SIGNED;
    if (LOGS_IN1 == LOGS_IN0)
      word_rel = REL_EQ;
    else if (use_signed ? ($signed(LOGS_IN1) > $signed(LOGS_IN0)) : (LOGS_IN1 > LOGS_IN0))
      word_rel = REL_GT;
    else
      word_rel = REL_LT;

    fin_rel = ((state_q == ST_CHAIN) && decided_q) ? rel_q : word_rel;

    if (accept) begin
      if (is_cmp && LOGS_CHAIN) begin
        if ((state_q == ST_IDLE) || !decided_q) begin
          rel_nxt     = word_rel;
          decided_nxt = (word_rel != REL_EQ);
        end
      end else begin
        rel_nxt     = REL_EQ;
        decided_nxt = 1'b0;
      end
    end

    if (is_cmp) begin
      case (LOGS_CMODE)
        3'b000:  flag_nxt[EQ_BIT] = (fin_rel == REL_EQ);
        3'b001:  flag_nxt[EQ_BIT] = (fin_rel != REL_EQ);
        3'b010:  flag_nxt[GT_BIT] = (fin_rel == REL_GT);
        3'b011:  flag_nxt[LT_BIT] = (fin_rel != REL_GT);
        3'b100:  flag_nxt[LT_BIT] = (fin_rel == REL_LT);
        3'b101:  flag_nxt[GT_BIT] = (fin_rel != REL_LT);
        default: flag_nxt = LOGS_FLAG_in;
      endcase
    end else begin
      out_nxt = logic_res;
`ifdef LOGS_ZERO_FLAG_EN
      flag_nxt[ZERO_BIT] = (logic_res == '0);
`else
      flag_nxt[ZERO_BIT] = LOGS_FLAG_in[ZERO_BIT];
`endif
    end
  end

  // Chain accumulators and output registers
  always_ff @(posedge LOGS_CLK) begin
    if (LOGS_RST) begin
      rel_q          <= REL_EQ;
      decided_q      <= 1'b0;
      LOGS_OUT_VALID <= 1'b0;
      LOGS_OUT       <= '0;
      LOGS_FLAG_out  <= '0;
    end else begin
      rel_q     <= rel_nxt;
      decided_q <= decided_nxt;
      if (load) begin
        LOGS_OUT_VALID <= 1'b1;
        LOGS_OUT       <= out_nxt;
        LOGS_FLAG_out  <= flag_nxt;
      end else if (LOGS_OUT_READY) begin
        LOGS_OUT_VALID <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_log_seq_unit.sv
// Bench for log_seq_unit: directed cases plus randomized traffic against a wide-integer reference model.
module tb_log_seq_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, sgn, chain, out_valid, out_ready;
  logic [15:0] in1, in0, flag_in, out, flag_out;
  logic [2:0]  mode, cmode;

  int tests = 0;
  int fails = 0;

  // Reference model state: chain words are concatenated into wide integers
  logic         m_live = 1'b0;
  logic         m_valid = 1'b0;
  logic [15:0]  m_out = '0;
  logic [15:0]  m_flag = '0;
  logic         m_sgn = 1'b0;
  int           m_n = 0;
  logic [255:0] m_a = '0;
  logic [255:0] m_b = '0;

  always #5 clk = ~clk;

  log_seq_unit dut (
    .LOGS_CLK       (clk),
    .LOGS_RST       (rst),
    .LOGS_IN_VALID  (in_valid),
    .LOGS_IN_READY  (in_ready),
    .LOGS_IN1       (in1),
    .LOGS_IN0       (in0),
    .LOGS_MODE      (mode),
    .LOGS_CMODE     (cmode),
    .LOGS_SIGNED    (sgn),
    .LOGS_CHAIN     (chain),
    .LOGS_FLAG_in   (flag_in),
    .LOGS_OUT_VALID (out_valid),
    .LOGS_OUT_READY (out_ready),
    .LOGS_OUT       (out),
    .LOGS_FLAG_out  (flag_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] logic_fn(input logic [2:0] md, input logic [15:0] a, input logic [15:0] b);
    case (md)
      3'd0:    return ~a;
      3'd1:    return a & b;
      3'd2:    return ~(a & b);
      3'd3:    return a | b;
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      default: return ~(a ^ b);
    endcase
  endfunction

  // Whole-number compare; signed order becomes unsigned by flipping the overall sign bit
  function automatic int wide_rel(input logic [255:0] a, input logic [255:0] b, input int n, input logic s);
    logic [255:0] as, bs;
    as = a << (256 - 16 * n);
    bs = b << (256 - 16 * n);
    if (s) begin
      as[255] = ~as[255];
      bs[255] = ~bs[255];
    end
    if (as == bs) return 0;
    return (as > bs) ? 1 : -1;
  endfunction

  function automatic logic [15:0] cmp_flags(input logic [15:0] f, input logic [2:0] cm, input int r);
    logic [15:0] g;
    g = f;
    case (cm)
      3'd0:    g[9] = (r == 0);
      3'd1:    g[9] = (r != 0);
      3'd2:    g[8] = (r > 0);
      3'd3:    g[7] = (r <= 0);
      3'd4:    g[7] = (r < 0);
      3'd5:    g[8] = (r >= 0);
      default: g = f;
    endcase
    return g;
  endfunction

  task automatic model_update();
    logic        ld;
    logic [15:0] res, f;
    int          r;
    ld  = 1'b0;
    res = '0;
    f   = '0;
    if (rst) begin
      m_valid = 1'b0; m_out = '0; m_flag = '0;
      m_n = 0; m_a = '0; m_b = '0;
    end else begin
      if (in_valid && (!m_valid || out_ready)) begin
        if (mode != 3'b111) begin
          m_n = 0; m_a = '0; m_b = '0;
          res = logic_fn(mode, in1, in0);
          f   = flag_in;
`ifdef LOGS_ZERO_FLAG_EN
          f[6] = (res == 16'h0000);
`endif
          ld = 1'b1;
        end else begin
          if (m_n == 0) m_sgn = sgn;
          m_a = {m_a[239:0], in1};
          m_b = {m_b[239:0], in0};
          m_n++;
          if (!chain) begin
            r   = wide_rel(m_a, m_b, m_n, m_sgn);
            f   = cmp_flags(flag_in, cmode, r);
            ld  = 1'b1;
            m_n = 0; m_a = '0; m_b = '0;
          end
        end
      end
      if (ld) begin
        m_valid = 1'b1; m_out = res; m_flag = f;
      end else if (out_ready) begin
        m_valid = 1'b0;
      end
    end
    m_live = 1'b1;
  endtask

  task automatic compare_outputs();
    if (m_live) begin
      chk("out_valid", 32'(out_valid), 32'(m_valid));
      if (m_valid) begin
        chk("out", 32'(out), 32'(m_out));
        chk("flag_out", 32'(flag_out), 32'(m_flag));
      end
    end
  endtask

  // One clock: check last results, drive new inputs, check ready, advance the model
  task automatic cycle(input logic r, input logic v, input logic [2:0] md, input logic [2:0] cm,
                       input logic s, input logic ch, input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] f, input logic ordy);
    @(negedge clk);
    compare_outputs();
    rst = r; in_valid = v; mode = md; cmode = cm; sgn = s; chain = ch;
    in1 = a; in0 = b; flag_in = f; out_ready = ordy;
    #1;
    if (m_live) chk("in_ready", 32'(in_ready), 32'(!m_valid || ordy));
    @(posedge clk);
    model_update();
  endtask

  initial begin
    logic [2:0]  md;
    logic [15:0] a, b;
    logic        ch;
    logic [15:0] zexp;

    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    #2;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_flag", 32'(flag_out), 32'd0);

    cycle(0, 1, 3'd1, 0, 0, 0, 16'hF0F0, 16'h3C3C, 16'h0001, 1);
    #2;
    chk("and_valid", 32'(out_valid), 32'd1);
    chk("and_out", 32'(out), 32'h3030);
    chk("and_flag", 32'(flag_out), 32'h0001);
    chk("model_and", 32'(m_out), 32'h3030);

    cycle(0, 1, 3'd7, 3'd2, 0, 0, 16'hFFFF, 16'h0001, 16'h0000, 1);
    #2 chk("gt_unsigned", 32'(flag_out), 32'h0100);
    cycle(0, 1, 3'd7, 3'd2, 1, 0, 16'hFFFF, 16'h0001, 16'h0000, 1);
    #2 chk("gt_signed", 32'(flag_out), 32'h0000);

    cycle(0, 1, 3'd7, 3'd4, 0, 1, 16'h1234, 16'h1234, 16'h0000, 1);
    cycle(0, 1, 3'd7, 3'd4, 0, 0, 16'h0005, 16'h0007, 16'h0000, 1);
    #2 chk("chain_lt_low", 32'(flag_out[7]), 32'd1);
    chk("model_chain_lt", 32'(m_flag), 32'h0080);
    cycle(0, 1, 3'd7, 3'd4, 0, 1, 16'h1235, 16'h1234, 16'h0000, 1);
    cycle(0, 1, 3'd7, 3'd4, 0, 0, 16'h0005, 16'h0007, 16'h0000, 1);
    #2 chk("chain_lt_high", 32'(flag_out[7]), 32'd0);

    cycle(0, 1, 3'd3, 0, 0, 0, 16'h1111, 16'h2222, 16'h0000, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, 3'd5, 0, 0, 0, 16'h00FF, 16'h0F0F, 16'h0000, 0);
      #2 chk("bp_hold", 32'(out), 32'h3333);
    end
    cycle(0, 1, 3'd5, 0, 0, 0, 16'h00FF, 16'h0F0F, 16'h0000, 1);
    #2 chk("bp_release", 32'(out), 32'h0FF0);
    cycle(0, 1, 3'd4, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 1);
    #2 chk("bp_next", 32'(out), 32'hFFFF);

    cycle(0, 1, 3'd7, 3'd0, 0, 1, 16'h00AA, 16'h00BB, 16'h0000, 1);
    cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    cycle(0, 1, 3'd7, 3'd0, 0, 0, 16'h00AA, 16'h00AA, 16'h0000, 1);
    #2 chk("rst_chain_eq", 32'(flag_out[9]), 32'd1);

`ifdef LOGS_ZERO_FLAG_EN
    zexp = 16'h0040;
`else
    zexp = 16'h0000;
`endif
    cycle(0, 1, 3'd5, 0, 0, 0, 16'h5A5A, 16'h5A5A, 16'h0000, 1);
    #2;
    chk("xor_zero_out", 32'(out), 32'h0000);
    chk("xor_zero_flag", 32'(flag_out), 32'(zexp));

    for (int i = 0; i < 3000; i++) begin
      md = ($urandom_range(0, 1) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
      a  = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       b = a;
        1:       b = a ^ (16'h1 << $urandom_range(0, 15));
        default: b = 16'($urandom);
      endcase
      ch = ($urandom_range(0, 9) < 4) && (m_n < 8);
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 7), md, 3'($urandom_range(0, 7)),
            1'($urandom), ch, a, b, 16'($urandom), ($urandom_range(0, 9) < 7));
    end

    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    compare_outputs();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/log_seq_unit.md
Name: log_seq_unit

Overview:
- Registered, parametrised successor of the 16-bit combinational logic/compare unit.
- Performs NOT/AND/NAND/OR/NOR/XOR/XNOR and six relational compares on DATA_W-bit operands; compares may be signed or unsigned.
- Adds multi-word chained compare (MSW first) for operands wider than DATA_W.
- Sits between the register-file read stage and flag/writeback, using a valid/ready handshake on both sides.

Parameters:
- DATA_W, 16: operand and result width.
- FLAG_W, 16: flag vector width.
- EQ_BIT, 9: flag bit written by EQ/NE.
- GT_BIT, 8: flag bit written by GT/GE.
- LT_BIT, 7: flag bit written by LT/LE.
- ZERO_BIT, 6: flag bit used only when LOGS_ZERO_FLAG_EN is defined.

Ports:
- LOGS_CLK  in  1  clock; all state updates on rising edge.
- LOGS_RST  in  1  synchronous, active-high reset.
- LOGS_IN_VALID  in  1  input word valid.
- LOGS_IN_READY  out  1  unit can accept input.
- LOGS_IN1  in  DATA_W  operand 1.
- LOGS_IN0  in  DATA_W  operand 0.
- LOGS_MODE  in  3  000 NOT, 001 AND, 010 NAND, 011 OR, 100 NOR, 101 XOR, 110 XNOR, 111 compare.
- LOGS_CMODE  in  3  000 EQ, 001 NE, 010 GT, 011 LE, 100 LT, 101 GE, 11x no-op.
- LOGS_SIGNED  in  1  two's-complement compare on the most significant word.
- LOGS_CHAIN  in  1  more words of this compare follow.
- LOGS_FLAG_in  in  FLAG_W  incoming flags.
- LOGS_OUT_VALID  out  1  result valid.
- LOGS_OUT_READY  in  1  downstream accepts result.
- LOGS_OUT  out  DATA_W  logic result.
- LOGS_FLAG_out  out  FLAG_W  updated flags.

Behaviour:
- Clock and reset: single clock LOGS_CLK; reset LOGS_RST is synchronous and active-high.
- Reset values: LOGS_OUT_VALID=0, LOGS_OUT=0, LOGS_FLAG_out=0, FSM=IDLE, chain accumulators cleared. Reset mid-chain abandons the chain; no output is produced for it.
- Handshake:
  - LOGS_IN_READY = !LOGS_OUT_VALID | LOGS_OUT_READY, combinational, in all states.
  - A word is accepted when IN_VALID & IN_READY.
  - Output registers hold stable while OUT_VALID & !OUT_READY.
  - OUT_VALID clears on OUT_READY unless a new final word is accepted in the same cycle; in that case OUT_VALID stays high and new data loads, giving 1 result/cycle throughput.
- Latency: result appears 1 cycle after acceptance of a final word.
- Logic modes (000-110):
  - LOGS_OUT is the bitwise function of IN1/IN0; NOT uses IN1 only.
  - FLAG_out = FLAG_in.
  - LOGS_CHAIN is ignored; the word is treated as final.
- Compare mode (111):
  - LOGS_OUT = 0.
  - FLAG_out = FLAG_in except one result bit:
    - EQ: EQ_BIT = (a==b); NE: EQ_BIT = (a!=b).
    - GT: GT_BIT = (a>b); GE: GT_BIT = (a>=b).
    - LT: LT_BIT = (a<b); LE: LT_BIT = (a<=b).
  - CMODE 11x: FLAG_out = FLAG_in.
- Signedness: applied only to the first (most significant) word of a compare; all later chain words compare unsigned.
- FSM states IDLE and CHAIN.
  - IDLE, compare word accepted with CHAIN=1:
    - Record rel = EQ/GT/LT of this word using LOGS_SIGNED.
    - Set decided = (rel!=EQ).
    - Go to CHAIN; no output produced.
  - CHAIN, compare word accepted with CHAIN=1: if !decided, update rel (unsigned) and decided; stay in CHAIN; no output.
  - CHAIN, compare word accepted with CHAIN=0:
    - Final rel = decided ? stored rel : this word's unsigned rel.
    - Output is produced using this word's CMODE and FLAG_in.
    - Return to IDLE.
  - CHAIN, logic-mode word accepted: chain aborted, accumulators cleared, return to IDLE; the logic word is processed normally.
  - IDLE, compare word accepted with CHAIN=0: single-word compare.
- Chain non-final words obey the same IN_READY rule.

Optional Feature:
- Macro LOGS_ZERO_FLAG_EN.
- When defined: for logic modes, FLAG_out[ZERO_BIT] = (result==0); all other flag bits pass through. Compare modes are unaffected.
- When undefined: FLAG_out[ZERO_BIT] passes FLAG_in like the other bits, and ZERO_BIT is unused.

Test Plan:
- Reset, then AND IN1=16'hF0F0, IN0=16'h3C3C, FLAG_in=16'h0001 -> next cycle OUT_VALID=1, OUT=16'h3030, FLAG_out=16'h0001.
- Compare GT, IN1=16'hFFFF, IN0=16'h0001, FLAG_in=0: SIGNED=0 -> FLAG_out=16'h0100; SIGNED=1 -> FLAG_out=16'h0000.
- Chained LT, SIGNED=0:
  - Word1 (1234,1234) CHAIN=1, word2 (0005,0007) CHAIN=0 -> one result, FLAG_out[7]=1.
  - Word1 (1235,1234) CHAIN=1, word2 (0005,0007) CHAIN=0 -> FLAG_out[7]=0.
- Backpressure: OUT_READY=0 for 3 cycles with IN_VALID held -> IN_READY=0, OUT/FLAG_out stable. OUT_READY=1 -> next word accepted the same cycle, back-to-back results, no loss or duplication.
- LOGS_RST after first chain word, then single EQ (0x00AA,0x00AA) -> no stray output; FLAG_out[9]=1.
- With LOGS_ZERO_FLAG_EN: XOR (0x5A5A,0x5A5A) -> OUT=0, FLAG_out[6]=1. Without the macro: FLAG_out[6]=FLAG_in[6].
